// File: rtl/cache_pkg.sv
// Shared defaults, FSM encoding and line-count clamp for the cache probe driver.
package cache_pkg;

  localparam int NUM_WAYS_DEF   = 8;
  localparam int ADDR_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWITCH = 3'd1,
    ST_PRIME  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_PROBE  = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } probe_state_e;

  function automatic logic [3:0] clamp_lines(input logic [3:0] n, input int ways);
    if (int'(n) > ways) return 4'(ways);
    return n;
  endfunction

endpackage

// File: rtl/cache_probe_driver_if.sv
// Cache-side bus: domain-switch strobe with way-mask, access strobe with address, registered hit.
interface cache_probe_driver_if
  import cache_pkg::*;
#(
  parameter int NUM_WAYS   = NUM_WAYS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  os_req;
  logic [NUM_WAYS-1:0]   hitmap;
  logic                  user_req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hit;

  modport master (output os_req, hitmap, user_req, addr, input hit);
  modport slave  (input os_req, hitmap, user_req, addr, output hit);
endinterface

// File: rtl/cache_probe_driver_popcount_ways.sv
// Combinational population count of the per-line probe hit vector.
module popcount_ways
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = NUM_WAYS_DEF
) (
  input  logic [NUM_WAYS-1:0] ways,
  output logic [3:0]          count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      count = count + 4'(ways[i]);
    end
  end

endmodule

// File: rtl/cache_probe_driver.sv
// Prime/wait/probe sequencer: switch domain, prime n lines, idle, probe n lines, report hits.
// Registered outputs, no backpressure; CACHE_PROBE_DBG_EN adds state_o/idx_o debug ports.
module cache_probe_driver
  import cache_pkg::*;
#(
  parameter int NUM_WAYS   = NUM_WAYS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_WAYS-1:0]   cfg_hitmap,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [3:0]            num_lines,
  input  logic [7:0]            wait_cycles,
  cache_probe_driver_if.master  cache,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_WAYS-1:0]   probe_hits,
  output logic [3:0]            hit_count
`ifdef CACHE_PROBE_DBG_EN
  ,
  output logic [2:0]            state_o,
  output logic [3:0]            idx_o
`endif
);

  probe_state_e          state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [3:0]            n_q;
  logic [3:0]            idx;
  logic [3:0]            next_idx;
  logic [3:0]            pidx;
  logic [7:0]            wait_q;
  logic [7:0]            cnt;
  logic                  pend;
  logic                  last;

  assign next_idx  = idx + 4'd1;
  assign last      = (next_idx == n_q);
  assign next_addr = base_q + ADDR_WIDTH'(next_idx);

  // pend/pidx remember last cycle's probe so its registered hit lands in the right bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cache.os_req   <= 1'b0;
      cache.hitmap   <= '0;
      cache.user_req <= 1'b0;
      cache.addr     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      probe_hits     <= '0;
      base_q         <= '0;
      n_q            <= '0;
      wait_q         <= '0;
      cnt            <= '0;
      idx            <= '0;
      pidx           <= '0;
      pend           <= 1'b0;
    end else begin
      pend <= (state == ST_PROBE);
      pidx <= idx;
      if (pend) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
          if (pidx == 4'(i)) probe_hits[i] <= cache.hit;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SWITCH;
            busy         <= 1'b1;
            cache.os_req <= 1'b1;
            cache.hitmap <= cfg_hitmap;
            base_q       <= base_addr;
            n_q          <= clamp_lines(num_lines, NUM_WAYS);
            wait_q       <= wait_cycles;
            probe_hits   <= '0;
          end
        end
        ST_SWITCH: begin
          cache.os_req <= 1'b0;
          cache.hitmap <= '0;
          idx          <= '0;
          if (n_q == 4'd0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state          <= ST_PRIME;
            cache.user_req <= 1'b1;
            cache.addr     <= base_q;
          end
        end
        ST_PRIME: begin
          if (last) begin
            idx <= '0;
            if (wait_q == 8'd0) begin
              state      <= ST_PROBE;
              cache.addr <= base_q;
            end else begin
              state          <= ST_WAIT;
              cnt            <= wait_q;
              cache.user_req <= 1'b0;
              cache.addr     <= '0;
            end
          end else begin
            idx        <= next_idx;
            cache.addr <= next_addr;
          end
        end
        ST_WAIT: begin
          if (cnt == 8'd1) begin
            state          <= ST_PROBE;
            cache.user_req <= 1'b1;
            cache.addr     <= base_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ST_PROBE: begin
          if (last) begin
            state          <= ST_DRAIN;
            cache.user_req <= 1'b0;
            cache.addr     <= '0;
          end else begin
            idx        <= next_idx;
            cache.addr <= next_addr;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  popcount_ways #(.NUM_WAYS(NUM_WAYS)) u_popcount (
    .ways  (probe_hits),
    .count (hit_count)
  );

`ifdef CACHE_PROBE_DBG_EN
  assign state_o = state;
  assign idx_o   = idx;
`endif

endmodule

// File: tb/tb_cache_probe_driver.sv
// Directed bench for cache_probe_driver against a small NRU single-set cache with domain way-masks.
module tb_cache_probe_driver;
  import cache_pkg::*;

  localparam int NW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NW-1:0] cfg_hitmap;
  logic [AW-1:0] base_addr;
  logic [3:0]    num_lines;
  logic [7:0]    wait_cycles;
  logic          busy;
  logic          done;
  logic [NW-1:0] probe_hits;
  logic [3:0]    hit_count;
`ifdef CACHE_PROBE_DBG_EN
  logic [2:0]    state_o;
  logic [3:0]    idx_o;
`endif

  cache_probe_driver_if #(.NUM_WAYS(NW), .ADDR_WIDTH(AW)) cif ();

  always #5 clk = ~clk;

  cache_probe_driver #(.NUM_WAYS(NW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_hitmap  (cfg_hitmap),
    .base_addr   (base_addr),
    .num_lines   (num_lines),
    .wait_cycles (wait_cycles),
    .cache       (cif),
    .busy        (busy),
    .done        (done),
    .probe_hits  (probe_hits),
    .hit_count   (hit_count)
`ifdef CACHE_PROBE_DBG_EN
    ,
    .state_o     (state_o),
    .idx_o       (idx_o)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // NRU cache model: one set of NW ways, lookups and fills restricted to the current domain mask
  logic [AW-1:0] tag_q [NW];
  logic          vld_q [NW];
  logic          used_q[NW];
  logic [NW-1:0] dom_mask;
  logic          flush;

  always @(posedge clk) begin : cache_model
    int way;
    int victim;
    if (flush) begin
      for (int i = 0; i < NW; i++) begin
        vld_q[i]  <= 1'b0;
        used_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
      dom_mask <= '0;
      cif.hit  <= 1'b0;
    end else begin
      if (cif.os_req) dom_mask <= cif.hitmap;
      cif.hit <= 1'b0;
      if (cif.user_req) begin
        way = -1;
        for (int i = 0; i < NW; i++)
          if (dom_mask[i] && vld_q[i] && tag_q[i] == cif.addr) way = i;
        if (way >= 0) begin
          cif.hit     <= 1'b1;
          used_q[way] <= 1'b1;
        end else begin
          victim = -1;
          for (int i = NW - 1; i >= 0; i--)
            if (dom_mask[i] && !used_q[i]) victim = i;
          if (victim < 0) begin
            for (int i = NW - 1; i >= 0; i--) begin
              if (dom_mask[i]) begin
                used_q[i] <= 1'b0;
                victim = i;
              end
            end
          end
          if (victim >= 0) begin
            tag_q[victim]  <= cif.addr;
            vld_q[victim]  <= 1'b1;
            used_q[victim] <= 1'b1;
          end
        end
      end
    end
  end

  // Per-sequence observations, cycle k counted from the cycle start was high
  int            os_k, os_cnt, ur_cnt, done_k, viol, busy_at_done;
  logic [NW-1:0] os_hm;
  int            ur_k[$];
  logic [AW-1:0] ur_addr[$];
  logic [31:0]   rst_snap;

  function automatic int uk(input int i);
    return (i < ur_k.size()) ? ur_k[i] : -1;
  endfunction

  function automatic logic [AW-1:0] ua(input int i);
    return (i < ur_addr.size()) ? ur_addr[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic run_seq(input logic [NW-1:0] hm, input logic [AW-1:0] base,
                         input logic [3:0] nl, input logic [7:0] wt,
                         input int restart_at, input int rst_at);
    os_k = -1; os_cnt = 0; ur_cnt = 0; done_k = -1; viol = 0; busy_at_done = 0;
    os_hm = '0; rst_snap = 32'hFFFF_FFFF;
    ur_k.delete();
    ur_addr.delete();
    flush = 1'b1;
    @(negedge clk);
    flush       = 1'b0;
    cfg_hitmap  = hm;
    base_addr   = base;
    num_lines   = nl;
    wait_cycles = wt;
    start       = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (cif.os_req) begin
        os_cnt++;
        if (os_k < 0) begin
          os_k  = k;
          os_hm = cif.hitmap;
        end
      end
      if (cif.user_req) begin
        ur_cnt++;
        ur_k.push_back(k);
        ur_addr.push_back(cif.addr);
      end
      if (cif.os_req && cif.user_req) viol++;
      if (!cif.user_req && cif.addr != '0) viol++;
      if (!cif.os_req && cif.hitmap != '0) viol++;
      if (k == 1) start = 1'b0;
      if (k == restart_at) begin
        start      = 1'b1;
        cfg_hitmap = 8'hFF;
        base_addr  = 32'h900;
      end
      if (k == restart_at + 1) start = 1'b0;
      if (k == rst_at + 1) begin
        rst_snap = {cif.os_req, cif.user_req, busy, done, hit_count, probe_hits,
                    cif.hitmap, 8'(cif.addr | (cif.addr >> 8) | (cif.addr >> 16) | (cif.addr >> 24))};
        reset = 1'b0;
        break;
      end
      if (k == rst_at) reset = 1'b1;
      if (done) begin
        done_k       = k;
        busy_at_done = int'(busy);
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b1;
    cfg_hitmap = '0; base_addr = '0; num_lines = '0; wait_cycles = '0;
    repeat (3) @(negedge clk);
    check("rst_os_req",   32'(cif.os_req),   0);
    check("rst_user_req", 32'(cif.user_req), 0);
    check("rst_hitmap",   32'(cif.hitmap),   0);
    check("rst_addr",     cif.addr,          0);
    check("rst_busy_done", 32'({busy, done}), 0);
    check("rst_hits",     32'({hit_count, probe_hits}), 0);
    reset = 1'b0;
    @(negedge clk);

    // Four lines in a four-way domain: primed lines survive, every probe hits
    run_seq(8'h0F, 32'h100, 4'd4, 8'd0, -1, -1);
    check("a_os_k",      os_k, 1);
    check("a_os_cnt",    os_cnt, 1);
    check("a_os_hitmap", 32'(os_hm), 32'h0F);
    check("a_ur_cnt",    ur_cnt, 8);
    check("a_ur_first",  uk(0), 2);
    check("a_prime_end", uk(3), 5);
    check("a_probe_beg", uk(4), 6);
    check("a_probe_end", uk(7), 9);
    check("a_addr0",     ua(0), 32'h100);
    check("a_addr3",     ua(3), 32'h103);
    check("a_addr4",     ua(4), 32'h100);
    check("a_addr7",     ua(7), 32'h103);
    check("a_done_k",    done_k, 11);
    check("a_busy_done", busy_at_done, 1);
    check("a_hits",      32'(probe_hits), 32'h0F);
    check("a_count",     32'(hit_count), 4);
    check("a_strobes",   viol, 0);
    @(negedge clk);
    check("a_idle_busy", 32'({busy, done}), 0);
    check("a_hold_hits", 32'(probe_hits), 32'h0F);
    check("a_hold_cnt",  32'(hit_count), 4);

    // Zero lines: switch then straight to done, old hits cleared
    run_seq(8'h0F, 32'h180, 4'd0, 8'd0, -1, -1);
    check("c_os_k",   os_k, 1);
    check("c_done_k", done_k, 2);
    check("c_ur_cnt", ur_cnt, 0);
    check("c_hits",   32'(probe_hits), 0);
    check("c_count",  32'(hit_count), 0);

    // Four lines through a two-way domain thrash under NRU: every probe misses
    run_seq(8'h03, 32'h200, 4'd4, 8'd0, -1, -1);
    check("b_ur_cnt",  ur_cnt, 8);
    check("b_done_k",  done_k, 11);
    check("b_hits",    32'(probe_hits), 0);
    check("b_count",   32'(hit_count), 0);
    check("b_strobes", viol, 0);

    // Twelve lines clamp to eight; base near the top wraps the address
    run_seq(8'hFF, 32'hFFFF_FFFC, 4'd12, 8'd0, -1, -1);
    check("d_ur_cnt",  ur_cnt, 16);
    check("d_addr0",   ua(0), 32'hFFFF_FFFC);
    check("d_addr4",   ua(4), 32'h0);
    check("d_addr7",   ua(7), 32'h3);
    check("d_addr8",   ua(8), 32'hFFFF_FFFC);
    check("d_addr15",  ua(15), 32'h3);
    check("d_done_k",  done_k, 19);
    check("d_hits",    32'(probe_hits), 32'hFF);
    check("d_count",   32'(hit_count), 8);
    check("d_strobes", viol, 0);

    // Three strobe-free cycles between last prime and first probe
    run_seq(8'h0F, 32'h400, 4'd2, 8'd3, -1, -1);
    check("e_ur_cnt",    ur_cnt, 4);
    check("e_prime_end", uk(1), 3);
    check("e_probe_beg", uk(2), 7);
    check("e_gap",       uk(2) - uk(1) - 1, 3);
    check("e_done_k",    done_k, 10);
    check("e_hits",      32'(probe_hits), 32'h03);
    check("e_count",     32'(hit_count), 2);
    check("e_strobes",   viol, 0);

    // Restart while busy is ignored; reset in the second probe cycle clears everything
    run_seq(8'h0F, 32'h500, 4'd4, 8'd0, 3, 7);
    check("f_os_cnt",   os_cnt, 1);
    check("f_probe_a0", ua(4), 32'h500);
    check("f_ur_cnt",   ur_cnt, 6);
    check("f_done",     done_k, -1);
    check("f_rst_outs", rst_snap, 0);
`ifdef CACHE_PROBE_DBG_EN
    check("f_rst_state", 32'(state_o), 0);
`endif
    @(negedge clk);
    check("f_post_busy", 32'({busy, cif.os_req, cif.user_req}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/cache_probe_driver.md
CACHE_PROBE_DRIVER -- requirements
Module: cache_probe_driver

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 8, number of cache ways and width of hitmap and probe result.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of the tag address.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to run a prime/wait/probe sequence.
REQ-006 SHALL have port cfg_hitmap  input  NUM_WAYS  domain way-mask issued with the switch.
REQ-007 SHALL have port base_addr  input  ADDR_WIDTH  first line address; line i uses base_addr+i, modulo 2^ADDR_WIDTH.
REQ-008 SHALL have port num_lines  input  4  lines to prime and probe; values above NUM_WAYS are clamped to NUM_WAYS.
REQ-009 SHALL have port wait_cycles  input  8  idle gap between prime and probe.
REQ-010 SHALL have port os_req  output  1  domain-switch strobe to the cache.
REQ-011 SHALL have port hitmap  output  NUM_WAYS  way-mask that accompanies os_req.
REQ-012 SHALL have port user_req  output  1  access strobe to the cache.
REQ-013 SHALL have port addr  output  ADDR_WIDTH  access address that accompanies user_req.
REQ-014 SHALL have port hit  input  1  registered cache response, valid the cycle after user_req.
REQ-015 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), probe_hits (output, NUM_WAYS, bit i = line i hit) and hit_count (output, 4, popcount of probe_hits).

Function
REQ-016 SHALL implement FSM IDLE->SWITCH->PRIME->WAIT->PROBE->DRAIN->DONE->IDLE.
REQ-017 SHALL leave IDLE only on start=1, latching all cfg inputs and the clamped num_lines (n) and clearing probe_hits.
REQ-018 SHALL, in SWITCH (1 cycle), drive os_req=1 with hitmap=latched cfg_hitmap.
REQ-019 SHALL, in PRIME, issue n back-to-back user_req cycles, addr=base+0..n-1.
REQ-020 SHALL, in WAIT, hold all strobes low for exactly wait_cycles cycles; 0 skips WAIT.
REQ-021 SHALL, in PROBE, issue n back-to-back user_req cycles, addr=base+0..n-1, and in each cycle after a probe issue (PROBE or DRAIN) record hit into probe_hits[i-1 of that issue].
REQ-022 SHALL hold DRAIN for 1 cycle to capture the last probe hit.
REQ-023 SHALL hold DONE for 1 cycle, asserting done=1 with final probe_hits and hit_count stable.
REQ-024 SHALL go SWITCH->DONE directly when n=0, with probe_hits=0.
REQ-025 SHALL never assert os_req and user_req in the same cycle; addr and hitmap SHALL be 0 when their strobe is low.
REQ-026 SHALL assert busy in every non-IDLE state and ignore start while busy.
REQ-027 SHALL hold probe_hits and hit_count after DONE until the next accepted start.

Reset
REQ-028 SHALL, on reset=1 (including mid-sequence), enter IDLE with os_req, user_req, hitmap, addr, busy, done, probe_hits and hit_count all 0 on the following cycle.

Configuration
REQ-029 SHALL, with macro CACHE_PROBE_DBG_EN defined, add outputs state_o (3 bits, FSM encoding) and idx_o (4 bits, current line index); without it these ports SHALL NOT exist and behaviour SHALL be otherwise identical.

Structure
REQ-030 SHALL take NUM_WAYS, ADDR_WIDTH defaults and the FSM state enum from shared package cache_pkg.
REQ-031 SHALL place the popcount in a sub-module popcount_ways.

Verification
REQ-032 SHALL cover this case against the NRU cacheline: start at t, hitmap=8'h0F, base=0x100, n=4, wait=0 -> os_req at t+1, user_req t+2..t+5 and t+6..t+9, done at t+11, probe_hits=8'h0F, hit_count=4.
REQ-033 SHALL cover this case: hitmap=8'h03, base=0x200, n=4, wait=0 -> all probes miss through NRU thrash; probe_hits=8'h00, hit_count=0.
REQ-034 SHALL cover this case: n=0 -> os_req at t+1, done at t+2, no user_req, probe_hits=0.
REQ-035 SHALL cover this case: n=12 -> clamped to 8; 8 prime and 8 probe accesses, base+0..base+7 only.
REQ-036 SHALL cover this case: start repeated while busy is ignored, and reset asserted during PROBE -> all outputs 0 next cycle, state IDLE.
REQ-037 SHALL cover this case: wait=3 -> exactly 3 strobe-free cycles between the last prime access and the first probe access.
